// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter and its address mapper.
//   - FSM state encoding and bus-owner encoding
//   - kseg0/kseg1 segment constants and the byte-strobe width
//   - is_unmapped_seg(): true for the directly mapped kernel segments
package sram_bus_arbiter_pkg;

    localparam int BSEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // OWN_INST is the all-zero encoding so the reset owner reads as 0
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [2:0] KSEG0_SEG = 3'b100;
    localparam logic [2:0] KSEG1_SEG = 3'b101;
    localparam logic [2:0] PHYS_SEG  = 3'b000;

    function automatic logic is_unmapped_seg(input logic [2:0] seg);
        return (seg == KSEG0_SEG) || (seg == KSEG1_SEG);
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_addr_map.sv
// Combinational virtual-to-physical address mapper.
// kseg0/kseg1 addresses lose their top three bits; every other address
// passes through untouched.
//   vaddr_i : virtual address
//   paddr_o : physical address
module sram_bus_arbiter_addr_map
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] vaddr_i,
    output logic [ADDR_W-1:0] paddr_o
);

    // Strip the segment bits for the directly mapped kernel segments
    always_comb begin
        if (is_unmapped_seg(vaddr_i[ADDR_W-1 -: 3])) begin
            paddr_o = {PHYS_SEG, vaddr_i[ADDR_W-4:0]};
        end else begin
            paddr_o = vaddr_i;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbiter sharing one SRAM-like bus between instruction fetch and data memory.
// One transaction at a time runs through IDLE -> ADDR -> DATA -> RESP.
//   cpu_clk_50M, cpu_rst_n         : clock, async active-low reset
//   inst_req/inst_addr             : fetch request (level) and virtual address
//   inst_rdata/inst_ok             : fetched word and one-cycle valid pulse
//   dce/daddr/we/din               : data request, address, byte enables, store data
//   data_rdata/data_ok             : load word and one-cycle completion pulse
//   flush                          : pipeline flush, discards an inst response
//   stall_req                      : stall request to the pipeline controller
//   bus_req/wr/wstrb/addr/wdata    : bus request outputs (physical address)
//   bus_addr_ok/data_ok/rdata      : bus handshake and read data
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ok,
    input  logic              dce,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [BSEL_W-1:0] we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ok,
    input  logic              flush,
    output logic              stall_req,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [BSEL_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_e              state_q,      state_d;
    owner_e              owner_q,      owner_d;
    logic                drop_q,       drop_d;
    logic                bus_req_q,    bus_req_d;
    logic                bus_wr_q,     bus_wr_d;
    logic [BSEL_W-1:0]   bus_wstrb_q,  bus_wstrb_d;
    logic [ADDR_W-1:0]   bus_addr_q,   bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q,  bus_wdata_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                inst_ok_q,    inst_ok_d;
    logic                data_ok_q,    data_ok_d;

    logic [ADDR_W-1:0]   req_vaddr_s;
    logic [ADDR_W-1:0]   req_paddr_s;

    // dce wins the grant, so its address is the one presented to the mapper
    assign req_vaddr_s = dce ? daddr : inst_addr;

    sram_bus_arbiter_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .vaddr_i (req_vaddr_s),
        .paddr_o (req_paddr_s)
    );

    // Next-state and datapath-register update for the bus sequencer
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;

        // A flush while a fetch is in flight only marks its response for discard;
        // the bus transaction itself always runs to completion.
        if (flush && (owner_q == OWN_INST) && (state_q != ST_IDLE)) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (!flush && (dce || inst_req)) begin
                    bus_req_d  = 1'b1;
                    bus_addr_d = req_paddr_s;
                    state_d    = ST_ADDR;
                    if (dce) begin
                        owner_d     = OWN_DATA;
                        bus_wr_d    = (we != {BSEL_W{1'b0}});
                        bus_wstrb_d = we;
                        bus_wdata_d = din;
                    end else begin
                        owner_d     = OWN_INST;
                        bus_wr_d    = 1'b0;
                        bus_wstrb_d = {BSEL_W{1'b0}};
                        bus_wdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // data_ok in this cycle is ignored: the slave only answers after addr_ok
                if (bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_DATA) begin
                        data_ok_d = 1'b1;
                        if (!bus_wr_q) begin
                            data_rdata_d = bus_rdata;
                        end else begin
                            data_rdata_d = data_rdata_q;
                        end
                    end else begin
                        inst_ok_d    = ~drop_d;
                        inst_rdata_d = bus_rdata;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                drop_d    = 1'b0;
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every visible output
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            drop_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_wstrb_q  <= {BSEL_W{1'b0}};
            bus_addr_q   <= {ADDR_W{1'b0}};
            bus_wdata_q  <= {DATA_W{1'b0}};
            inst_rdata_q <= {DATA_W{1'b0}};
            data_rdata_q <= {DATA_W{1'b0}};
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wr     = bus_wr_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ok    = inst_ok_q;
    assign data_ok    = data_ok_q;

    // Stall must follow a new request in the same cycle, so it is combinational;
    // it is gated with reset so every output reads 0 while reset is held.
    assign stall_req = cpu_rst_n & ((dce & ~data_ok_q) | (inst_req & ~inst_ok_q));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        flush;
    logic        stall_req;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int tests = 0;
    int fails = 0;

    // expected contents of the two read-data registers
    logic [31:0] m_drdata = 32'h0;
    logic [31:0] m_irdata = 32'h0;

    // bus slave configuration and transaction log
    int          s_addr_dly = 0;
    int          s_data_dly = 1;
    logic [31:0] s_rdata    = 32'h0;
    int          s_cnt      = 0;
    int          s_dcnt     = 0;
    bit          s_pend     = 1'b0;
    int          s_txn_cnt  = 0;
    logic [31:0] s_last_addr;
    logic        s_last_wr;
    logic [3:0]  s_last_wstrb;
    logic [31:0] s_last_wdata;
    logic [31:0] s_addr_q[$];

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_ok     (inst_ok),
        .dce         (dce),
        .daddr       (daddr),
        .we          (we),
        .din         (din),
        .data_rdata  (data_rdata),
        .data_ok     (data_ok),
        .flush       (flush),
        .stall_req   (stall_req),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus slave: addr_ok after s_addr_dly request cycles, data_ok s_data_dly cycles later
    always @(posedge clk) begin
        #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (!rst_n) begin
            s_cnt  = 0;
            s_pend = 1'b0;
        end else if (s_pend) begin
            if (s_dcnt <= 1) begin
                bus_data_ok = 1'b1;
                bus_rdata   = s_rdata;
                s_pend      = 1'b0;
            end else begin
                s_dcnt = s_dcnt - 1;
            end
        end else if (bus_req) begin
            if (s_cnt >= s_addr_dly) begin
                bus_addr_ok  = 1'b1;
                s_pend       = 1'b1;
                s_dcnt       = s_data_dly;
                s_cnt        = 0;
                s_txn_cnt    = s_txn_cnt + 1;
                s_last_addr  = bus_addr;
                s_last_wr    = bus_wr;
                s_last_wstrb = bus_wstrb;
                s_last_wdata = bus_wdata;
                s_addr_q.push_back(bus_addr);
            end else begin
                s_cnt = s_cnt + 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    // Reference address map: kseg0/kseg1 is the window 0x8000_0000..0xBFFF_FFFF,
    // folded onto the low 512 MB.
    function automatic logic [31:0] ref_map(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hC000_0000) return va % 32'h2000_0000;
        else return va;
    endfunction

    // One complete transaction from the IDLE state. Called and returns at posedge+1.
    task automatic run_one(input string nm, input bit is_d, input logic [31:0] va,
                           input logic [3:0] wev, input logic [31:0] wd, input logic [31:0] rd,
                           input int ad, input int dd, input int fl, input logic [31:0] exp_pa);
        int  lat;
        int  cnt0;
        int  nb_req, nb_stall, nb_ok;
        bit  dropped, is_store;
        bit  e_req, e_dok, e_iok, e_stall;
        lat      = 2 + ad + dd;
        cnt0     = s_txn_cnt;
        nb_req   = 0;
        nb_stall = 0;
        nb_ok    = 0;
        dropped  = !is_d && (fl > 0);
        is_store = is_d && (wev != 4'h0);
        s_addr_dly = ad;
        s_data_dly = dd;
        s_rdata    = rd;
        if (is_d) begin
            daddr = va; we = wev; din = wd; dce = 1'b1;
        end else begin
            inst_addr = va; inst_req = 1'b1;
        end
        for (int c = 0; c <= lat + 2; c++) begin
            flush = (c == fl);
            if (c == lat + 1) begin
                dce = 1'b0;
                inst_req = 1'b0;
            end
            @(negedge clk);
            e_req   = (c >= 1) && (c <= 1 + ad);
            e_dok   = is_d && (c == lat);
            e_iok   = !is_d && !dropped && (c == lat);
            e_stall = (c < lat) || ((c == lat) && dropped);
            if (bus_req !== e_req) nb_req++;
            if (stall_req !== e_stall) nb_stall++;
            if (data_ok !== e_dok || inst_ok !== e_iok) nb_ok++;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        if (is_d && !is_store) m_drdata = rd;
        if (!is_d) m_irdata = rd;
        check({nm, "_busreq_window"}, nb_req, 0);
        check({nm, "_stall_cycles"}, nb_stall, 0);
        check({nm, "_ok_pulses"}, nb_ok, 0);
        check({nm, "_txn_count"}, s_txn_cnt - cnt0, 1);
        check({nm, "_bus_addr"}, s_last_addr, exp_pa);
        check({nm, "_bus_wr"}, {31'h0, s_last_wr}, {31'h0, is_store});
        check({nm, "_bus_wstrb"}, {28'h0, s_last_wstrb}, is_d ? {28'h0, wev} : 32'h0);
        if (is_store) check({nm, "_bus_wdata"}, s_last_wdata, wd);
        check({nm, "_data_rdata"}, data_rdata, m_drdata);
        check({nm, "_inst_rdata"}, inst_rdata, m_irdata);
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] va;
        logic [3:0]  wev;
        logic [31:0] wd;
        logic [31:0] rd;
        int          ad;
        int          dd;
        int          fl;
        logic [31:0] exp_pa;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          nb;
        logic [2:0]  seg;
        logic [31:0] rnd, va, wd;
        logic [3:0]  wev;
        bit          is_d;
        int          ad, dd, fl, lat;

        rst_n = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; dce = 1'b0; daddr = 32'h0;
        we = 4'h0; din = 32'h0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

        vecs[0] = '{1'b1, 32'h8000_0010, 4'h0,    32'h0000_0000, 32'hDEAD_BEEF, 0, 1, -1, 32'h0000_0010};
        vecs[1] = '{1'b1, 32'hBFAF_F000, 4'b0011, 32'h1234_5678, 32'h55AA_55AA, 0, 1, -1, 32'h1FAF_F000};
        vecs[2] = '{1'b0, 32'hBFC0_0000, 4'h0,    32'h0000_0000, 32'h3C08_BFC0, 0, 1, -1, 32'h1FC0_0000};
        vecs[3] = '{1'b1, 32'h9FFF_FFFC, 4'h0,    32'h0000_0000, 32'h0BAD_F00D, 0, 2, -1, 32'h1FFF_FFFC};
        vecs[4] = '{1'b1, 32'h7FFF_FFFC, 4'h0,    32'h0000_0000, 32'h1111_2222, 1, 1, -1, 32'h7FFF_FFFC};
        vecs[5] = '{1'b0, 32'hC000_0000, 4'h0,    32'h0000_0000, 32'h3333_4444, 0, 1, -1, 32'hC000_0000};
        vecs[6] = '{1'b1, 32'hA000_0000, 4'h0,    32'h0000_0000, 32'h7654_3210, 3, 4, -1, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h8000_0100, 4'h0,    32'h0000_0000, 32'hCAFE_F00D, 0, 3,  3, 32'h0000_0100};
        vecs[8] = '{1'b0, 32'h8000_0104, 4'h0,    32'h0000_0000, 32'h0104_0104, 0, 1, -1, 32'h0000_0104};
        vecs[9] = '{1'b1, 32'hFFFF_FFF0, 4'b1111, 32'hA5A5_0F0F, 32'h9999_9999, 2, 1, -1, 32'hFFFF_FFF0};

        // reset state
        #12;
        check("reset_bus_req", {31'h0, bus_req}, 32'h0);
        check("reset_stall", {31'h0, stall_req}, 32'h0);
        check("reset_oks", {30'h0, inst_ok, data_ok}, 32'h0);
        check("reset_bus_addr", bus_addr, 32'h0);
        check("reset_rdata", data_rdata | inst_rdata, 32'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].va, vecs[i].wev, vecs[i].wd,
                    vecs[i].rd, vecs[i].ad, vecs[i].dd, vecs[i].fl, vecs[i].exp_pa);
        end

        // simultaneous requests: data first, inst granted right after data's response
        s_addr_dly = 0; s_data_dly = 1; s_rdata = 32'h600D_DA7A;
        daddr = 32'h8000_0040; we = 4'h0; dce = 1'b1;
        inst_addr = 32'hBFC0_0010; inst_req = 1'b1;
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin dce = 1'b0; s_rdata = 32'h1D1D_1D1D; end
            if (c == 8) inst_req = 1'b0;
            @(negedge clk);
            if (data_ok !== (c == 3)) nb++;
            if (inst_ok !== (c == 7)) nb++;
            if (stall_req !== (c <= 6)) nb++;
            if (bus_req !== (c == 1 || c == 5)) nb++;
            @(posedge clk);
            #1;
        end
        m_drdata = 32'h600D_DA7A;
        m_irdata = 32'h1D1D_1D1D;
        check("simul_sequence", nb, 0);
        check("simul_first_addr", s_addr_q[s_addr_q.size()-2], 32'h0000_0040);
        check("simul_second_addr", s_addr_q[s_addr_q.size()-1], 32'h1FC0_0010);
        check("simul_data_rdata", data_rdata, m_drdata);
        check("simul_inst_rdata", inst_rdata, m_irdata);

        // reset while in ADDR
        s_addr_dly = 5; s_data_dly = 1; s_rdata = 32'h0;
        daddr = 32'h8000_0020; we = 4'h0; dce = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_bus_req", {31'h0, bus_req}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_async_ctrl", {28'h0, bus_wr, inst_ok, data_ok, stall_req}, 32'h0);
        check("rst_async_bus_addr", bus_addr, 32'h0);
        check("rst_async_wstrb_wdata", bus_wdata | {28'h0, bus_wstrb}, 32'h0);
        check("rst_async_rdata", data_rdata | inst_rdata, 32'h0);
        dce = 1'b0;
        m_drdata = 32'h0;
        m_irdata = 32'h0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_one("post_reset", 1'b1, 32'h8000_0030, 4'h0, 32'h0, 32'hFACE_0001, 0, 1, -1, 32'h0000_0030);

        // randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            seg  = 3'($urandom_range(0, 7));
            rnd  = $urandom;
            va   = {seg, rnd[28:2], 2'b00};
            is_d = 1'($urandom_range(0, 1));
            wev  = (is_d && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            wd   = $urandom;
            ad   = $urandom_range(0, 3);
            dd   = $urandom_range(1, 4);
            lat  = 2 + ad + dd;
            fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : -1;
            run_one($sformatf("rnd%0d", i), is_d, va, wev, wd, $urandom, ad, dd, fl, ref_map(va));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
